// File: rtl/and_stim_sequencer.sv
// Stimulus scheduler for the two-input AND test FSM: walks a fixed 12-step {i1,i2}/dwell
// table, checks dut_y against i1&i2 at the end of each dwell and keeps a sticky error flag.
module and_stim_sequencer #(
   parameter int unsigned NUM_STEPS = 12,
   parameter int unsigned CNT_W     = 12,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic       dut_y,
   output logic       i1,
   output logic       i2,
   output logic [3:0] step,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [3:0] err_step
);

   localparam int unsigned   PreW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);
   localparam logic [3:0]    LastStep = 4'(NUM_STEPS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [3:0]       step_q, step_d;
   logic             i1_q, i1_d, i2_q, i2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PreW-1:0]  pre_q, pre_d;
   logic             err_q, err_d;
   logic [3:0]       err_step_q, err_step_d;
   logic             tick;
   logic [3:0]       step_nxt;

   // {i1,i2} level pair of a table entry
   function automatic logic [1:0] step_pat(input logic [3:0] s);
      logic [1:0] p;
      case (s)
         4'd0:    p = 2'b10;
         4'd1:    p = 2'b11;
         4'd2:    p = 2'b01;
         4'd3:    p = 2'b00;
         4'd4:    p = 2'b10;
         4'd5:    p = 2'b11;
         4'd6:    p = 2'b01;
         4'd7:    p = 2'b00;
         4'd8:    p = 2'b01;
         4'd9:    p = 2'b11;
         4'd10:   p = 2'b01;
         default: p = 2'b00;
      endcase
      return p;
   endfunction

   // Counter load value: dwell in ticks minus one
   function automatic logic [CNT_W-1:0] step_load(input logic [3:0] s);
      logic [CNT_W-1:0] c;
      case (s)
         4'd4, 4'd7: c = CNT_W'(299);
         4'd6, 4'd8: c = CNT_W'(199);
         default:    c = CNT_W'(499);
      endcase
      return c;
   endfunction

   assign tick     = (state_q == StRun) && !pause && (pre_q == PreLast);
   assign step_nxt = step_q + 4'd1;

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      i1_d       = i1_q;
      i2_d       = i2_q;
      cnt_d      = cnt_q;
      pre_d      = pre_q;
      err_d      = err_q;
      err_step_d = err_step_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d      = StRun;
               step_d       = 4'd0;
               {i1_d, i2_d} = step_pat(4'd0);
               cnt_d        = step_load(4'd0);
               pre_d        = '0;
               err_d        = 1'b0;
               err_step_d   = 4'd0;
            end
         end
         StRun: begin
            if (!pause) begin
               pre_d = tick ? '0 : pre_q + PreW'(1);
            end
            if (tick) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  if (dut_y != (i1_q & i2_q)) begin
                     err_d = 1'b1;
                     if (!err_q) err_step_d = step_q;
                  end
                  if (step_q != LastStep) begin
                     step_d       = step_nxt;
                     {i1_d, i2_d} = step_pat(step_nxt);
                     cnt_d        = step_load(step_nxt);
                  end else begin
                     state_d = StDone;
                     step_d  = 4'd0;
                     i1_d    = 1'b0;
                     i2_d    = 1'b0;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         step_q     <= 4'd0;
         i1_q       <= 1'b0;
         i2_q       <= 1'b0;
         cnt_q      <= '0;
         pre_q      <= '0;
         err_q      <= 1'b0;
         err_step_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         i1_q       <= i1_d;
         i2_q       <= i2_d;
         cnt_q      <= cnt_d;
         pre_q      <= pre_d;
         err_q      <= err_d;
         err_step_q <= err_step_d;
      end
   end

   assign i1       = i1_q;
   assign i2       = i2_q;
   assign step     = step_q;
   assign busy     = (state_q == StRun);
   assign done     = (state_q == StDone);
   assign err      = err_q;
   assign err_step = err_step_q;

endmodule

// File: tb/tb_and_stim_sequencer.sv
// Bench for and_stim_sequencer: directed timing scenarios plus randomized runs, with every
// cycle compared against a table-driven model working on elapsed clocks.
module tb_and_stim_sequencer;

   localparam bit [1:0] PAT [12] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11,
                                     2'b01, 2'b00, 2'b01, 2'b11, 2'b01, 2'b00};
   localparam int DWELL [12] = '{500, 500, 500, 500, 300, 500, 200, 300, 200, 500, 500, 500};

   typedef struct packed {
      bit          run;
      bit          done;
      bit          err;
      bit [3:0]    es;
      int unsigned t;
   } mst_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0, pause = 1'b0, flip = 1'b0, force0 = 1'b0;
   logic dut_y, i1, i2, busy, done, err;
   logic [3:0] step, err_step;
   logic start3 = 1'b0, pause3 = 1'b0;
   logic dut_y3, i1_3, i2_3, busy3, done3, err3;
   logic [3:0] step3, err_step3;
   bit   chk_en = 1'b0;
   int   checks = 0, failures = 0;
   mst_t ms = '0, ms3 = '0;

   always #5 clk = ~clk;

   assign dut_y  = force0 ? 1'b0 : ((i1 & i2) ^ flip);
   assign dut_y3 = i1_3 & i2_3;

   and_stim_sequencer #(.NUM_STEPS(12), .CNT_W(12), .TICK_DIV(1)) dut (
      .clk(clk), .reset(reset), .start(start), .pause(pause), .dut_y(dut_y),
      .i1(i1), .i2(i2), .step(step), .busy(busy), .done(done), .err(err),
      .err_step(err_step)
   );

   and_stim_sequencer #(.NUM_STEPS(12), .CNT_W(12), .TICK_DIV(3)) dut3 (
      .clk(clk), .reset(reset), .start(start3), .pause(pause3), .dut_y(dut_y3),
      .i1(i1_3), .i2(i2_3), .step(step3), .busy(busy3), .done(done3), .err(err3),
      .err_step(err_step3)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Total ticks up to and including the end of step k
   function automatic int cum_thru(input int k);
      int acc = 0;
      for (int j = 0; j <= k; j++) acc += DWELL[j];
      return acc;
   endfunction

   function automatic int step_of(input int unsigned t, input int td);
      int ticks = int'(t) / td;
      for (int k = 0; k < 12; k++) if (ticks < cum_thru(k)) return k;
      return 11;
   endfunction

   function automatic mst_t mnext(input mst_t s, input bit st, input bit pa, input bit y,
                                  input int td);
      int k;
      bit [1:0] p;
      if (!s.run) begin
         if (st) begin
            s.run = 1'b1; s.done = 1'b0; s.err = 1'b0; s.es = 4'd0; s.t = 0;
         end
      end else if (!pa) begin
         k = step_of(s.t, td);
         p = PAT[k];
         if (int'(s.t) + 1 == cum_thru(k) * td) begin
            if (y != (p[1] & p[0])) begin
               if (!s.err) s.es = 4'(k);
               s.err = 1'b1;
            end
            if (k == 11) begin
               s.run = 1'b0; s.done = 1'b1;
            end
         end
         s.t++;
      end
      return s;
   endfunction

   function automatic logic [12:0] mout(input mst_t s, input int td);
      int k;
      if (!s.run) return {2'b00, 4'd0, 1'b0, s.done, s.err, s.es};
      k = step_of(s.t, td);
      return {PAT[k], 4'(k), 1'b1, 1'b0, s.err, s.es};
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         ms  <= '0;
         ms3 <= '0;
      end else begin
         ms  <= mnext(ms, start, pause, dut_y, 1);
         ms3 <= mnext(ms3, start3, pause3, dut_y3, 3);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check_eq("cyc", {i1, i2, step, busy, done, err, err_step}, 32'(mout(ms, 1)));
         check_eq("cyc3", {i1_3, i2_3, step3, busy3, done3, err3, err_step3},
                  32'(mout(ms3, 3)));
      end
   end

   task automatic next_cyc();
      @(posedge clk);
      #2;
   endtask

   // One run on the TICK_DIV=1 instance; returns busy length and number of step-6 samples
   task automatic run_seq(input int pause_at, input int pause_len, input bit ign_starts,
                          input int rst_step, input bit rnd, output int n, output int n6);
      next_cyc();
      start = 1'b1;
      next_cyc();
      start = 1'b0;
      check_eq("start_busy", 32'(busy), 32'd1);
      check_eq("start_done", 32'(done), 32'd0);
      check_eq("start_err", 32'(err), 32'd0);
      n  = 0;
      n6 = 0;
      while (busy === 1'b1 && n < 20000) begin
         if (step == 4'd6) n6++;
         pause = (pause_at >= 0) && (n >= pause_at) && (n < pause_at + pause_len);
         start = ign_starts && (n == 100 || n == 4999);
         if (rnd) begin
            pause = ($urandom_range(0, 7) == 0);
            start = ($urandom_range(0, 99) == 0);
            flip  = ($urandom_range(0, 199) == 0);
         end
         if (rst_step >= 0 && step == 4'(rst_step)) begin
            reset = 1'b0;
            #1;
            check_eq("rst_midrun", 32'({i1, i2, step, busy, done, err, err_step}), 32'd0);
         end
         next_cyc();
         n++;
      end
      pause = 1'b0;
      start = 1'b0;
      flip  = 1'b0;
      if (!reset) begin
         next_cyc();
         next_cyc();
         check_eq("rst_hold_done", 32'(done), 32'd0);
         reset = 1'b1;
      end
   endtask

   initial begin
      int n, n6;
      #1 reset = 1'b0;
      #1 chk_en = 1'b1;
      // Reset held for three clocks, then released
      for (int c = 0; c < 3; c++) begin
         next_cyc();
         check_eq("rst_outs", 32'({i1, i2, step, busy, done, err, err_step}), 32'd0);
      end
      reset = 1'b1;
      next_cyc();
      next_cyc();
      check_eq("post_rst_idle", 32'({i1, i2, busy, done}), 32'd0);

      // Nominal
      run_seq(-1, 0, 1'b0, -1, 1'b0, n, n6);
      check_eq("nom_busy_len", 32'(n), 32'd5000);
      check_eq("nom_done", 32'(done), 32'd1);
      check_eq("nom_err", 32'(err), 32'd0);

      // dut_y stuck at 0: first 11 pattern is step 1
      force0 = 1'b1;
      run_seq(-1, 0, 1'b0, -1, 1'b0, n, n6);
      force0 = 1'b0;
      check_eq("flt_busy_len", 32'(n), 32'd5000);
      check_eq("flt_err", 32'(err), 32'd1);
      check_eq("flt_err_step", 32'(err_step), 32'd1);

      // Starts while busy are ignored; this start from DONE also clears err
      run_seq(-1, 0, 1'b1, -1, 1'b0, n, n6);
      check_eq("ign_busy_len", 32'(n), 32'd5000);
      check_eq("ign_done", 32'(done), 32'd1);

      // 37-clock pause inside step 6
      run_seq(2900, 37, 1'b0, -1, 1'b0, n, n6);
      check_eq("pau_busy_len", 32'(n), 32'd5037);
      check_eq("pau_step6_len", 32'(n6), 32'd237);

      // Reset during step 7
      run_seq(-1, 0, 1'b0, 7, 1'b0, n, n6);
      check_eq("rst_after_done", 32'(done), 32'd0);

      // Randomized pause, stray starts and output flips
      for (int r = 0; r < 3; r++) begin
         run_seq(-1, 0, 1'b0, -1, 1'b1, n, n6);
         check_eq("rnd_done", 32'(done), 32'd1);
      end

      // TICK_DIV=3 instance
      next_cyc();
      start3 = 1'b1;
      next_cyc();
      start3 = 1'b0;
      n = 0;
      while (busy3 === 1'b1 && n < 20000) begin
         next_cyc();
         n++;
      end
      check_eq("td3_busy_len", 32'(n), 32'd15000);
      check_eq("td3_done", 32'(done3), 32'd1);
      check_eq("td3_err", 32'(err3), 32'd0);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
